msg_serialiser: RTL and testbench

MSG_SERIALISER -- requirements
Module: msg_serialiser

---
 rtl/msg_serialiser.sv | 176 +++++++++++++++++
 tb/tb_msg_serialiser.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_serialiser.sv
`default_nettype none
// ============================================================================
//  Module      : msg_serialiser
//  Description : Accepts a packed multi-word message in one handshake and
//                emits it one word at a time on a valid/ready stream, with an
//                optional header word and selectable word order.
//  Revision    : 1.0 - initial release
// ============================================================================
module msg_serialiser #(
    parameter int                   WORD_SIZE   = 8,
    parameter int                   MAX_WORDS   = 4,
    parameter bit                   MSB_FIRST   = 1'b0,
    parameter bit                   HEADER_EN   = 1'b0,
    parameter logic [WORD_SIZE-1:0] HEADER_WORD = WORD_SIZE'(8'hA5),
    localparam int                  LEN_W       = $clog2(MAX_WORDS + 1),
    localparam int                  IN_W        = WORD_SIZE * MAX_WORDS
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic [IN_W-1:0]      data_in,
    input  logic [LEN_W-1:0]     data_in_len,
    input  logic                 data_in_valid,
    output logic                 ready,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 data_out_last,
    output logic                 len_err
);

    // Word index width; a single-word configuration still needs one bit.
    localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_TX   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [IN_W-1:0]        r_data;        // captured message payload
    logic [WORD_SIZE-1:0]   r_data_out;
    logic                   r_last;
    logic [IDX_W-1:0]       r_cnt;         // index of the word currently presented
    logic [LEN_W-1:0]       r_remain;      // payload words not yet transferred
    logic                   r_len_err;

    logic [WORD_SIZE-1:0]   w_dout_nxt;
    logic                   w_last_nxt;
    logic [IDX_W-1:0]       w_cnt_nxt;
    logic [LEN_W-1:0]       w_remain_nxt;

    logic                   w_len_ok;
    logic                   w_accept;
    logic                   w_xfer;
    logic [IDX_W-1:0]       w_first_idx;
    logic [IDX_W-1:0]       w_cnt_step;
    logic [LEN_W-1:0]       w_len_m1;
    logic [LEN_W-1:0]       w_remain_dec;

    // Select word idx from a packed message; indices past the top word give 0.
    function automatic logic [WORD_SIZE-1:0] f_word(input logic [IN_W-1:0]  vec,
                                                    input logic [IDX_W-1:0] idx);
        logic [WORD_SIZE-1:0] word;
        word = '0;
        for (int i = 0; i < MAX_WORDS; i++) begin
            if (int'(idx) == i) begin
                word = vec[i*WORD_SIZE +: WORD_SIZE];
            end
        end
        return word;
    endfunction

    assign ready          = (r_state == S_IDLE);
    assign data_out_valid = (r_state != S_IDLE);
    assign data_out       = r_data_out;
    assign data_out_last  = r_last;
    assign len_err        = r_len_err;

    assign w_len_ok     = (data_in_len != '0) && (data_in_len <= LEN_W'(MAX_WORDS));
    assign w_accept     = ready && data_in_valid && w_len_ok;
    assign w_xfer       = data_out_valid && data_out_ready;
    assign w_len_m1     = data_in_len - LEN_W'(1);
    assign w_first_idx  = MSB_FIRST ? w_len_m1[IDX_W-1:0] : '0;
    assign w_cnt_step   = MSB_FIRST ? (r_cnt - IDX_W'(1)) : (r_cnt + IDX_W'(1));
    assign w_remain_dec = r_remain - LEN_W'(1);

    // Next-state and next output-word decode; registers only move on accept or transfer.
    always_comb begin
        w_state_nxt  = r_state;
        w_dout_nxt   = r_data_out;
        w_last_nxt   = r_last;
        w_cnt_nxt    = r_cnt;
        w_remain_nxt = r_remain;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt    = w_first_idx;
                    w_remain_nxt = data_in_len;
                    if (HEADER_EN) begin
                        w_state_nxt = S_HDR;
                        w_dout_nxt  = HEADER_WORD;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_TX;
                        w_dout_nxt  = f_word(data_in, w_first_idx);
                        w_last_nxt  = (data_in_len == LEN_W'(1));
                    end
                end
            end
            S_HDR: begin
                if (w_xfer) begin
                    w_state_nxt = S_TX;
                    w_dout_nxt  = f_word(r_data, r_cnt);
                    w_last_nxt  = (r_remain == LEN_W'(1));
                end
            end
            S_TX: begin
                if (w_xfer) begin
                    if (r_last) begin
                        w_state_nxt  = S_IDLE;
                        w_dout_nxt   = '0;
                        w_last_nxt   = 1'b0;
                        w_cnt_nxt    = '0;
                        w_remain_nxt = '0;
                    end else begin
                        w_cnt_nxt    = w_cnt_step;
                        w_remain_nxt = w_remain_dec;
                        w_dout_nxt   = f_word(r_data, w_cnt_step);
                        w_last_nxt   = (w_remain_dec == LEN_W'(1));
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output word, last flag, index and remaining-count registers plus length-error pulse.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_data_out <= '0;
            r_last     <= 1'b0;
            r_cnt      <= '0;
            r_remain   <= '0;
            r_len_err  <= 1'b0;
        end else begin
            r_data_out <= w_dout_nxt;
            r_last     <= w_last_nxt;
            r_cnt      <= w_cnt_nxt;
            r_remain   <= w_remain_nxt;
            r_len_err  <= ready && data_in_valid && !w_len_ok;
        end
    end

    // Payload capture on accept so the source may change data_in afterwards.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data <= data_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_msg_serialiser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msg_serialiser
//  Description : Scoreboard bench for msg_serialiser. Instance 0 uses default
//                parameters, instance 1 is MSB-first with a header word; both
//                share the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_msg_serialiser;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [31:0] data_in;
    logic [2:0]  data_in_len;
    logic        data_in_valid;
    logic        data_out_ready;

    logic [7:0]  dout [2];
    logic        vld  [2];
    logic        lst  [2];
    logic        rdy  [2];
    logic        lerr [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0]  q0[$];          // {last, word} expected from instance 0
    logic [8:0]  q1[$];          // {last, word} expected from instance 1
    int          xfers0 = 0;
    int          lerr_cnt [2] = '{0, 0};

    always #5 clk = ~clk;

    msg_serialiser dut0 (
        .clk            (clk),
        .n_reset        (n_reset),
        .data_in        (data_in),
        .data_in_len    (data_in_len),
        .data_in_valid  (data_in_valid),
        .ready          (rdy[0]),
        .data_out       (dout[0]),
        .data_out_valid (vld[0]),
        .data_out_ready (data_out_ready),
        .data_out_last  (lst[0]),
        .len_err        (lerr[0])
    );

    msg_serialiser #(
        .MSB_FIRST (1'b1),
        .HEADER_EN (1'b1)
    ) dut1 (
        .clk            (clk),
        .n_reset        (n_reset),
        .data_in        (data_in),
        .data_in_len    (data_in_len),
        .data_in_valid  (data_in_valid),
        .ready          (rdy[1]),
        .data_out       (dout[1]),
        .data_out_valid (vld[1]),
        .data_out_ready (data_out_ready),
        .data_out_last  (lst[1]),
        .len_err        (lerr[1])
    );

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d): got %0h, expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer, checks hold-stability while stalled.
    logic       stall  [2] = '{1'b0, 1'b0};
    logic [7:0] held_d [2];
    logic       held_l [2];
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!n_reset) begin
                stall[k] = 1'b0;
            end else begin
                if (stall[k]) begin
                    chk("hold valid", k, 32'(vld[k]), 32'd1);
                    chk("hold data",  k, 32'(dout[k]), 32'(held_d[k]));
                    chk("hold last",  k, 32'(lst[k]), 32'(held_l[k]));
                end
                if (lerr[k]) lerr_cnt[k]++;
                if (vld[k] && data_out_ready) begin
                    logic [8:0] e;
                    int         sz;
                    sz = (k == 0) ? q0.size() : q1.size();
                    chk("word expected", k, 32'(sz > 0), 32'd1);
                    if (sz > 0) begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk("data_out", k, 32'(dout[k]), 32'(e[7:0]));
                        chk("data_out_last", k, 32'(lst[k]), 32'(e[8]));
                    end
                    if (k == 0) xfers0++;
                end
                stall[k]  = vld[k] && !data_out_ready;
                held_d[k] = dout[k];
                held_l[k] = lst[k];
            end
        end
    end

    task automatic push0(input logic [7:0] w, input logic l);
        q0.push_back({l, w});
    endtask

    task automatic push1(input logic [7:0] w, input logic l);
        q1.push_back({l, w});
    endtask

    // Offer one message once both instances are idle; scrambles data_in after accept.
    task automatic offer(input logic [31:0] d, input logic [2:0] len);
        int n = 0;
        while (!(rdy[0] && rdy[1]) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("offer ready timeout", 0, 32'(n < 100), 32'd1);
        data_in       = d;
        data_in_len   = len;
        data_in_valid = 1'b1;
        @(posedge clk); #1;
        data_in_valid = 1'b0;
        data_in       = 32'hFFFF_FFFF;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(rdy[0] && rdy[1] && q0.size() == 0 && q1.size() == 0) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("drain timeout", 0, 32'(n < 100), 32'd1);
    endtask

    // Illegal length: no output, ready stays high, one-cycle len_err pulse.
    task automatic offer_bad(input logic [2:0] len);
        data_in       = 32'h4433_2211;
        data_in_len   = len;
        data_in_valid = 1'b1;
        @(posedge clk); #1;
        data_in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("len_err pulse", k, 32'(lerr[k]), 32'd1);
            chk("ready after bad len", k, 32'(rdy[k]), 32'd1);
            chk("no valid after bad len", k, 32'(vld[k]), 32'd0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            chk("len_err one cycle", k, 32'(lerr[k]), 32'd0);
            chk("ready still high", k, 32'(rdy[k]), 32'd1);
        end
    endtask

    task automatic push_std();
        push0(8'h11, 1'b0); push0(8'h22, 1'b0); push0(8'h33, 1'b0); push0(8'h44, 1'b1);
        push1(8'hA5, 1'b0); push1(8'h44, 1'b0); push1(8'h33, 1'b0); push1(8'h22, 1'b0); push1(8'h11, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        n_reset        = 1'b0;
        data_in        = '0;
        data_in_len    = '0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset ready", k, 32'(rdy[k]), 32'd1);
            chk("reset valid", k, 32'(vld[k]), 32'd0);
            chk("reset data_out", k, 32'(dout[k]), 32'd0);
            chk("reset last", k, 32'(lst[k]), 32'd0);
            chk("reset len_err", k, 32'(lerr[k]), 32'd0);
        end
        n_reset = 1'b1;
        @(posedge clk); #1;

        // Full-rate message; source keeps offering junk while busy.
        push_std();
        offer(32'h4433_2211, 3'd4);
        data_in_valid = 1'b1;
        data_in_len   = 3'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        data_in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("one word per cycle, drained", 0, 32'(q0.size()), 32'd0);
        chk("ready right after last", 0, 32'(rdy[0]), 32'd1);
        chk("valid low after last", 0, 32'(vld[0]), 32'd0);
        wait_idle();

        // Three-word message: word 3 never appears.
        push0(8'hAA, 1'b0); push0(8'hBB, 1'b0); push0(8'hCC, 1'b1);
        push1(8'hA5, 1'b0); push1(8'hCC, 1'b0); push1(8'hBB, 1'b0); push1(8'hAA, 1'b1);
        offer(32'h00CC_BBAA, 3'd3);
        wait_idle();

        // Single-word message.
        push0(8'h5A, 1'b1);
        push1(8'hA5, 1'b0); push1(8'h5A, 1'b1);
        offer(32'h1234_565A, 3'd1);
        wait_idle();

        // Backpressure pattern 1,0,0,1,0,0,...
        push_std();
        offer(32'h4433_2211, 3'd4);
        for (int i = 0; i < 60; i++) begin
            data_out_ready = (i % 3 == 0);
            @(posedge clk); #1;
            if (rdy[0] && rdy[1] && q0.size() == 0 && q1.size() == 0) break;
        end
        data_out_ready = 1'b1;
        wait_idle();

        // Illegal lengths.
        offer_bad(3'd0);
        offer_bad(3'd5);

        // Reset after the second word.
        push0(8'h11, 1'b0); push0(8'h22, 1'b0);
        push1(8'hA5, 1'b0); push1(8'h44, 1'b0);
        base = xfers0;
        offer(32'h4433_2211, 3'd4);
        n = 0;
        while (xfers0 < base + 2 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("two words before reset", 0, 32'(xfers0 - base), 32'd2);
        n_reset        = 1'b0;
        data_out_ready = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            chk("valid low after reset", k, 32'(vld[k]), 32'd0);
        end
        n_reset        = 1'b1;
        data_out_ready = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            chk("ready after reset release", k, 32'(rdy[k]), 32'd1);
        end
        push_std();
        offer(32'h4433_2211, 3'd4);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard empty", 0, 32'(q0.size()), 32'd0);
        chk("scoreboard empty", 1, 32'(q1.size()), 32'd0);
        chk("len_err pulse count", 0, 32'(lerr_cnt[0]), 32'd2);
        chk("len_err pulse count", 1, 32'(lerr_cnt[1]), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
